// File: rtl/lsu_ctrl.sv
// Load/store unit between execute and data memory: one op per transaction, alignment/funct3 check, load extension.
// Latency: store occupies one REQ cycle; load result pulses on wb_valid three cycles after acceptance.
// Backpressure: stall is high whenever a transaction is in flight; ops presented while stalled are ignored.
module lsu_ctrl #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic              op_store,
    input  logic [2:0]        funct3,
    input  logic [31:0]       addr,
    input  logic [31:0]       store_data,
    input  logic [4:0]        rd_in,
    output logic              stall,
    output logic              dm_request,
    output logic              dm_we_re,
    output logic              dm_load,
    output logic [3:0]        dm_mask,
    output logic [ADDR_W-1:0] dm_address,
    output logic [31:0]       dm_data_in,
    input  logic              dm_valid,
    input  logic [31:0]       dm_data_out,
    output logic              wb_valid,
    output logic [31:0]       wb_data,
    output logic [4:0]        wb_rd,
    output logic              exc_valid,
    output logic              exc_cause,
    output logic [31:0]       exc_addr
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t      state;
    logic        store_q;
    logic [1:0]  off_q;
    logic [2:0]  f3_q;
    logic [4:0]  rd_q;

    logic        op_illegal;
    logic        op_misaligned;
    logic [3:0]  op_mask;
    logic [31:0] op_sdata;

    // High address bits wrap into memory and are deliberately ignored.
    logic unused_addr_hi;
    assign unused_addr_hi = &{1'b0, addr[31:ADDR_W+2]};

    assign stall = (state != IDLE);

    // Aligns and extends the returned word according to the latched width/sign code.
    function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] off,
                                            input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{off, 3'b000} +: 8];
        h = off[1] ? w[31:16] : w[15:0];
        case (f3)
            3'd0:    extract = {{24{b[7]}}, b};
            3'd4:    extract = {24'd0, b};
            3'd1:    extract = {{16{h[15]}}, h};
            3'd5:    extract = {16'd0, h};
            default: extract = w;
        endcase
    endfunction

    // Decode the presented op: legality, alignment, store lane mask and replicated data.
    always_comb begin
        op_illegal    = 1'b0;
        op_misaligned = 1'b0;
        op_mask       = 4'b1111;
        op_sdata      = store_data;
        if (op_store)
            op_illegal = funct3[2] | (funct3[1:0] == 2'b11);
        else
            op_illegal = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7);
        op_misaligned = ((funct3[1:0] == 2'b01) && addr[0]) ||
                        ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
        case (funct3[1:0])
            2'b00: begin
                op_mask  = 4'b0001 << addr[1:0];
                op_sdata = {4{store_data[7:0]}};
            end
            2'b01: begin
                op_mask  = 4'b0011 << addr[1:0];
                op_sdata = {2{store_data[15:0]}};
            end
            default: begin
                op_mask  = 4'b1111;
                op_sdata = store_data;
            end
        endcase
    end

    // Transaction FSM with all memory, writeback and exception outputs registered.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            store_q    <= 1'b0;
            off_q      <= 2'b00;
            f3_q       <= 3'd0;
            rd_q       <= 5'd0;
            dm_request <= 1'b0;
            dm_we_re   <= 1'b0;
            dm_load    <= 1'b0;
            dm_mask    <= 4'b0000;
            dm_address <= '0;
            dm_data_in <= 32'd0;
            wb_valid   <= 1'b0;
            wb_data    <= 32'd0;
            wb_rd      <= 5'd0;
            exc_valid  <= 1'b0;
            exc_cause  <= 1'b0;
            exc_addr   <= 32'd0;
        end else begin
            // Strobes and pulses default low; data-like outputs hold.
            dm_request <= 1'b0;
            dm_we_re   <= 1'b0;
            dm_load    <= 1'b0;
            wb_valid   <= 1'b0;
            exc_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (op_valid) begin
                        if (op_illegal || op_misaligned) begin
                            // Illegal funct3 wins over misalignment when both apply.
                            exc_valid <= 1'b1;
                            exc_cause <= op_illegal;
                            exc_addr  <= addr;
                        end else begin
                            store_q    <= op_store;
                            off_q      <= addr[1:0];
                            f3_q       <= funct3;
                            rd_q       <= rd_in;
                            dm_request <= 1'b1;
                            dm_we_re   <= op_store;
                            dm_load    <= ~op_store;
                            dm_address <= addr[ADDR_W+1:2];
                            if (op_store) begin
                                dm_mask    <= op_mask;
                                dm_data_in <= op_sdata;
                            end else begin
                                dm_mask    <= 4'b1111;
                            end
                            state <= REQ;
                        end
                    end
                end
                REQ: begin
                    state <= store_q ? IDLE : WAIT;
                end
                WAIT: begin
                    if (dm_valid) begin
                        wb_data  <= extract(f3_q, off_q, dm_data_out);
                        wb_rd    <= rd_q;
                        wb_valid <= 1'b1;
                        state    <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized and directed bench for lsu_ctrl against a width/offset arithmetic reference model.
// Latency: checks every cycle of each transaction at the falling edge.
// Backpressure: the bench plays the memory, returning read data the cycle after dm_load.
module tb_lsu_ctrl;
    localparam int ADDR_W = 12;

    logic              clk = 1'b0;
    logic              rst;
    logic              op_valid, op_store;
    logic [2:0]        funct3;
    logic [31:0]       addr, store_data;
    logic [4:0]        rd_in;
    logic              stall, dm_request, dm_we_re, dm_load;
    logic [3:0]        dm_mask;
    logic [ADDR_W-1:0] dm_address;
    logic [31:0]       dm_data_in;
    logic              dm_valid;
    logic [31:0]       dm_data_out;
    logic              wb_valid;
    logic [31:0]       wb_data;
    logic [4:0]        wb_rd;
    logic              exc_valid, exc_cause;
    logic [31:0]       exc_addr;

    int vectors = 0;
    int miscompares = 0;

    lsu_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_store(op_store), .funct3(funct3),
        .addr(addr), .store_data(store_data), .rd_in(rd_in), .stall(stall),
        .dm_request(dm_request), .dm_we_re(dm_we_re), .dm_load(dm_load), .dm_mask(dm_mask),
        .dm_address(dm_address), .dm_data_in(dm_data_in), .dm_valid(dm_valid),
        .dm_data_out(dm_data_out), .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
        .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] w);
        int unsigned off, bv, hv;
        off = a % 4;
        bv  = (w >> (off * 8)) % 256;
        hv  = (w >> ((off / 2) * 16)) % 65536;
        case (f3)
            3'd0:    return (bv >= 128) ? bv + 32'hFFFF_FF00 : bv;
            3'd4:    return bv;
            3'd1:    return (hv >= 32768) ? hv + 32'hFFFF_0000 : hv;
            3'd5:    return hv;
            default: return w;
        endcase
    endfunction

    function automatic bit model_illegal(input bit st, input logic [2:0] f3);
        if (st) return f3 >= 3;
        return (f3 == 3) || (f3 == 6) || (f3 == 7);
    endfunction

    function automatic bit model_misaligned(input logic [2:0] f3, input logic [31:0] a);
        int unsigned size;
        size = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        return (a % size) != 0;
    endfunction

    function automatic logic [3:0] model_mask(input bit st, input logic [2:0] f3,
                                              input logic [31:0] a);
        int unsigned m;
        if (!st) m = 15;
        else if (f3 == 0) m = 1 << (a % 4);
        else if (f3 == 1) m = 3 << (a % 4);
        else m = 15;
        return 4'(m);
    endfunction

    function automatic logic [31:0] model_sdata(input logic [2:0] f3, input logic [31:0] sd);
        if (f3 == 0) return (sd % 256) * 32'h0101_0101;
        if (f3 == 1) return (sd % 65536) * 32'h0001_0001;
        return sd;
    endfunction

    function automatic logic [ADDR_W-1:0] model_waddr(input logic [31:0] a);
        return ADDR_W'((a / 4) % (1 << ADDR_W));
    endfunction

    // ---------------- one complete op, checked cycle by cycle ----------------
    task automatic apply_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] sd, input logic [4:0] rd,
                            input logic [31:0] w, input string tag);
        bit          ill, mis;
        logic [31:0] exp_wb;
        ill    = model_illegal(st, f3);
        mis    = model_misaligned(f3, a);
        exp_wb = model_load(f3, a, w);

        @(negedge clk);
        vectors++;
        if (stall !== 1'b0) begin
            $display("FAIL %s idle_stall got=%b want=0", tag, stall); miscompares++;
        end
        op_valid = 1'b1; op_store = st; funct3 = f3; addr = a; store_data = sd; rd_in = rd;

        @(negedge clk);
        op_valid = 1'b0; op_store = 1'($urandom); funct3 = 3'($urandom);
        addr = $urandom; store_data = $urandom; rd_in = 5'($urandom);
        if (ill || mis) begin
            vectors++;
            if ({exc_valid, exc_cause, exc_addr} !== {1'b1, ill, a} ||
                {dm_request, wb_valid, stall} !== 3'b000) begin
                $display("FAIL %s exc got v=%b c=%b a=%h req=%b wb=%b st=%b want v=1 c=%b a=%h req=0 wb=0 st=0",
                         tag, exc_valid, exc_cause, exc_addr, dm_request, wb_valid, stall, ill, a);
                miscompares++;
            end
            @(negedge clk);
            vectors++;
            if ({exc_valid, dm_request} !== 2'b00) begin
                $display("FAIL %s exc_pulse got v=%b req=%b want 0 0", tag, exc_valid, dm_request);
                miscompares++;
            end
            return;
        end

        vectors++;
        if ({dm_request, dm_we_re, dm_load, stall, exc_valid, wb_valid} !== {1'b1, st, !st, 1'b1, 1'b0, 1'b0} ||
            dm_mask !== model_mask(st, f3, a) || dm_address !== model_waddr(a)) begin
            $display("FAIL %s req got r=%b we=%b ld=%b st=%b m=%b ad=%h want r=1 we=%b ld=%b st=1 m=%b ad=%h",
                     tag, dm_request, dm_we_re, dm_load, stall, dm_mask, dm_address,
                     st, !st, model_mask(st, f3, a), model_waddr(a));
            miscompares++;
        end
        if (st) begin
            vectors++;
            if (dm_data_in !== model_sdata(f3, sd)) begin
                $display("FAIL %s store_data got=%h want=%h", tag, dm_data_in, model_sdata(f3, sd));
                miscompares++;
            end
            @(negedge clk);
            vectors++;
            if ({dm_request, dm_we_re, stall, wb_valid} !== 4'b0000) begin
                $display("FAIL %s store_done got r=%b we=%b st=%b wb=%b want 0000",
                         tag, dm_request, dm_we_re, stall, wb_valid);
                miscompares++;
            end
            return;
        end

        @(negedge clk);
        vectors++;
        if ({dm_request, dm_load, stall, wb_valid} !== 4'b0010) begin
            $display("FAIL %s wait got r=%b ld=%b st=%b wb=%b want 0010",
                     tag, dm_request, dm_load, stall, wb_valid);
            miscompares++;
        end
        dm_valid = 1'b1; dm_data_out = w;

        @(negedge clk);
        dm_valid = 1'b0; dm_data_out = $urandom;
        vectors++;
        if ({wb_valid, stall, exc_valid} !== 3'b110 || wb_data !== exp_wb || wb_rd !== rd) begin
            $display("FAIL %s resp got v=%b st=%b exc=%b d=%h rd=%0d want v=1 st=1 exc=0 d=%h rd=%0d",
                     tag, wb_valid, stall, exc_valid, wb_data, wb_rd, exp_wb, rd);
            miscompares++;
        end

        @(negedge clk);
        vectors++;
        if ({wb_valid, stall} !== 2'b00 || wb_data !== exp_wb) begin
            $display("FAIL %s after_resp got v=%b st=%b d=%h want v=0 st=0 d=%h",
                     tag, wb_valid, stall, wb_data, exp_wb);
            miscompares++;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b0; op_valid = 1'b0; op_store = 1'b0; funct3 = 3'd0; addr = 32'd0;
        store_data = 32'd0; rd_in = 5'd0; dm_valid = 1'b0; dm_data_out = 32'd0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({stall, dm_request, dm_we_re, dm_load, dm_mask, dm_address, dm_data_in, wb_valid,
             wb_data, wb_rd, exc_valid, exc_cause, exc_addr} !== '0) begin
            $display("FAIL reset_outputs got nonzero st=%b r=%b m=%b wb=%b exc=%b",
                     stall, dm_request, dm_mask, wb_valid, exc_valid);
            miscompares++;
        end
        rst = 1'b1;
    endtask

    task automatic test_store();
        apply_op(1'b1, 3'd2, 32'h0000_0104, 32'hDEAD_BEEF, 5'd0, 32'd0, "sw_104");
        apply_op(1'b1, 3'd0, 32'h0000_0107, 32'h0000_00A5, 5'd0, 32'd0, "sb_107");
        apply_op(1'b1, 3'd1, 32'h0000_0106, 32'hCAFE_1234, 5'd0, 32'd0, "sh_106");
    endtask

    task automatic test_load();
        apply_op(1'b0, 3'd0, 32'h0000_0105, 32'd0, 5'd7,  32'h1234_80FF, "lb_105");
        apply_op(1'b0, 3'd4, 32'h0000_0105, 32'd0, 5'd8,  32'h1234_80FF, "lbu_105");
        apply_op(1'b0, 3'd1, 32'h0000_0106, 32'd0, 5'd9,  32'h1234_80FF, "lh_106");
        apply_op(1'b0, 3'd2, 32'h0000_0104, 32'd0, 5'd31, 32'h1234_80FF, "lw_104");
        apply_op(1'b0, 3'd5, 32'hFFFF_FFFE, 32'd0, 5'd1,  32'h8001_7FFF, "lhu_wrap");
    endtask

    task automatic test_exception();
        apply_op(1'b0, 3'd2, 32'h0000_0102, 32'd0, 5'd3, 32'd0, "lw_misaligned");
        apply_op(1'b0, 3'd3, 32'h0000_0100, 32'd0, 5'd3, 32'd0, "load_f3_011");
        apply_op(1'b1, 3'd4, 32'h0000_0101, 32'd1, 5'd0, 32'd0, "store_f3_100");
        apply_op(1'b1, 3'd1, 32'h0000_0103, 32'd1, 5'd0, 32'd0, "sh_misaligned");
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        op_valid = 1'b1; op_store = 1'b0; funct3 = 3'd2; addr = 32'h0000_0200; rd_in = 5'd3;
        @(negedge clk);
        vectors++;
        if (dm_request !== 1'b1 || dm_address !== model_waddr(32'h200)) begin
            $display("FAIL b2b_first_req got r=%b ad=%h want r=1 ad=%h", dm_request, dm_address,
                     model_waddr(32'h200));
            miscompares++;
        end
        funct3 = 3'd1; addr = 32'h0000_0302; rd_in = 5'd9;   // second op held while stalled
        @(negedge clk);
        dm_valid = 1'b1; dm_data_out = 32'hA5A5_8001;
        @(negedge clk);
        dm_valid = 1'b0;
        vectors++;
        if ({wb_valid, dm_request} !== 2'b10 || wb_data !== 32'hA5A5_8001 || wb_rd !== 5'd3) begin
            $display("FAIL b2b_first_wb got v=%b r=%b d=%h rd=%0d want v=1 r=0 d=a5a58001 rd=3",
                     wb_valid, dm_request, wb_data, wb_rd);
            miscompares++;
        end
        @(negedge clk);
        vectors++;
        if ({stall, dm_request} !== 2'b00) begin
            $display("FAIL b2b_not_early got st=%b r=%b want 0 0", stall, dm_request);
            miscompares++;
        end
        @(negedge clk);
        op_valid = 1'b0;
        vectors++;
        if (dm_request !== 1'b1 || dm_address !== model_waddr(32'h302)) begin
            $display("FAIL b2b_second_req got r=%b ad=%h want r=1 ad=%h", dm_request, dm_address,
                     model_waddr(32'h302));
            miscompares++;
        end
        @(negedge clk);
        dm_valid = 1'b1; dm_data_out = 32'h8765_4321;
        @(negedge clk);
        dm_valid = 1'b0;
        vectors++;
        if (wb_valid !== 1'b1 || wb_data !== model_load(3'd1, 32'h302, 32'h8765_4321) || wb_rd !== 5'd9) begin
            $display("FAIL b2b_second_wb got v=%b d=%h rd=%0d want v=1 d=%h rd=9", wb_valid, wb_data,
                     wb_rd, model_load(3'd1, 32'h302, 32'h8765_4321));
            miscompares++;
        end
        @(negedge clk);
    endtask

    task automatic test_reset_in_wait();
        @(negedge clk);
        op_valid = 1'b1; op_store = 1'b0; funct3 = 3'd2; addr = 32'h0000_0040; rd_in = 5'd12;
        @(negedge clk);
        op_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0; dm_valid = 1'b1; dm_data_out = 32'h1111_2222;
        #1;
        vectors++;
        if ({stall, dm_request, dm_we_re, dm_load, dm_mask, dm_address, dm_data_in, wb_valid,
             wb_data, wb_rd, exc_valid, exc_cause, exc_addr} !== '0) begin
            $display("FAIL reset_in_wait got st=%b r=%b m=%b ad=%h wb=%b", stall, dm_request,
                     dm_mask, dm_address, wb_valid);
            miscompares++;
        end
        @(negedge clk);
        rst = 1'b1; dm_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            vectors++;
            if ({wb_valid, stall, exc_valid, dm_request} !== 4'b0000) begin
                $display("FAIL post_reset_quiet cyc=%0d got wb=%b st=%b exc=%b r=%b want 0000",
                         i, wb_valid, stall, exc_valid, dm_request);
                miscompares++;
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom % 2 == 1) a[1:0] = 2'b00;
            apply_op(1'($urandom), 3'($urandom), a, $urandom, 5'($urandom), $urandom, "random");
        end
    endtask

    initial begin
        test_reset();
        test_store();
        test_load();
        test_exception();
        test_back_to_back();
        test_reset_in_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end
endmodule
